// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the DDR3 byte-port arbiter.
// Optional feature macro: DDRAM_ARB_RR_EN (round-robin arbitration).
package ddram_arb_pkg;
    localparam int DDR_ADDR_W = 28;
    localparam int DDR_DATA_W = 8;
    localparam int MAX_REQ    = 8;

    typedef enum logic [1:0] {GAP, IDLE, ISSUE, WAIT} arb_state_t;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ddram_arb_pick.sv
// Combinational grant picker: fixed priority, or round-robin from ptr when
// DDRAM_ARB_RR_EN is defined.
module ddram_arb_pick
    import ddram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);

`ifdef DDRAM_ARB_RR_EN
    logic [IW-1:0] j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = IW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = j;
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/ddram_arbiter.sv
// Shares one DDR3 byte port among NUM_REQ requesters, one transaction at a time.
// Define DDRAM_ARB_RR_EN for round-robin; fixed priority (lowest index) otherwise.
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                                  DDRAM_CLK,
    input  logic                                  reset,
    input  logic                                  DDRAM_BUSY,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ-1:0][DDR_ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][DDR_DATA_W-1:0]    req_din,
    output logic [NUM_REQ-1:0]                    ack,
    output logic [DDR_DATA_W-1:0]                 rdata,
    output logic [DDR_ADDR_W-1:0]                 mem_addr,
    output logic [DDR_DATA_W-1:0]                 mem_din,
    output logic                                  mem_we,
    output logic                                  mem_rd,
    input  logic [DDR_DATA_W-1:0]                 mem_dout,
    input  logic                                  mem_ready
);

    localparam int IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("ddram_arbiter: NUM_REQ out of range 2..8");
    end

    arb_state_t         state, state_nx;
    logic [NUM_REQ-1:0] pick_gnt, gnt_q;
    logic [IW-1:0]      pick_idx, ptr;
    logic               pick_any, type_we, load, done;

    ddram_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) state <= GAP;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            GAP:   if (mem_ready && !DDRAM_BUSY) state_nx = IDLE;
            IDLE:  if (pick_any)                 state_nx = ISSUE;
            ISSUE: if (!mem_ready)               state_nx = WAIT;
            WAIT:  if (mem_ready)                state_nx = GAP;
            default:                             state_nx = GAP;
        endcase
    end

    // Strobes decode straight from flops; GAP keeps them low so the port
    // always samples a 0 before the next rising edge.
    always_comb begin
        load   = 1'b0;
        done   = 1'b0;
        mem_rd = 1'b0;
        mem_we = 1'b0;
        case (state)
            IDLE:  load = pick_any;
            ISSUE: begin
                mem_we = type_we;
                mem_rd = !type_we;
            end
            WAIT:  done = mem_ready;
            default: ;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            ack      <= '0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            type_we  <= 1'b0;
            gnt_q    <= '0;
        end else begin
            ack <= done ? gnt_q : '0;
            if (load) begin
                mem_addr <= req_addr[pick_idx];
                mem_din  <= req_din[pick_idx];
                type_we  <= req_we[pick_idx];
                gnt_q    <= pick_gnt;
            end
            if (done && !type_we) rdata <= mem_dout;
        end
    end

`ifdef DDRAM_ARB_RR_EN
    // ptr holds the next search start, i.e. last grant + 1.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset)     ptr <= '0;
        else if (load) ptr <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif

endmodule
